hit_judge_core: RTL and testbench

- Parametrised hit-judging datapath for the whack-a-mole game; successor to the single-compare play_sound logic.
- Synchronises and debounces the Arduino box address, then judges each strike against the current target within a timed window.
- Keeps a saturating score and a streak count, and drives a timed play_sound pulse.
- Sits between read_sensor/GPIO and the audio/VGA/HEX consumers. The level FSM supplies targets.

---
 rtl/hit_judge_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_hit_judge_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge_core.sv
`default_nettype none
// ============================================================================
// Module   : hit_judge_core
// Purpose  : Hit-judging datapath for the whack-a-mole game. Synchronises and
//            debounces the Arduino box address, judges each strike against the
//            armed target inside a timed window, keeps a saturating score and
//            streak, and drives a timed play_sound pulse.
// Ports    : CLOCK_50      system clock
//            reset         asynchronous active-high reset
//            enable        game active; low forces IDLE
//            score_clear   synchronous score/streak clear
//            target_addr   box to hit, sampled with target_valid
//            target_valid  one-cycle pulse: load a new target and arm
//            sensor_addr   raw asynchronous box address (0 = no box)
//            score         current score (saturating)
//            streak        consecutive hits (saturating at 255)
//            hit_pulse     one-cycle pulse on a correct strike
//            wrong_pulse   one-cycle pulse on a wrong-box strike
//            miss_pulse    one-cycle pulse on window expiry
//            play_sound    high for SOUND_TICKS ticks after a hit
//            armed         high while a target is armed
// Revision : 1.0 - initial release
// ============================================================================
module hit_judge_core #(
    parameter int ADDR_W         = 3,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int WINDOW_TICKS   = 1000,
    parameter int SOUND_TICKS    = 200,
    parameter int SCORE_W        = 11
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               enable,
    input  logic               score_clear,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic               target_valid,
    input  logic [ADDR_W-1:0]  sensor_addr,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic               hit_pulse,
    output logic               wrong_pulse,
    output logic               miss_pulse,
    output logic               play_sound,
    output logic               armed
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_db_w   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int c_win_w  = $clog2(WINDOW_TICKS + 1);
    localparam int c_snd_w  = $clog2(SOUND_TICKS + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_TICKS - 1);
    localparam logic [c_db_w-1:0]   c_db_full   = c_db_w'(DEBOUNCE_TICKS);
    localparam logic [c_win_w-1:0]  c_win_full  = c_win_w'(WINDOW_TICKS);
    localparam logic [c_snd_w-1:0]  c_snd_load  = c_snd_w'(SOUND_TICKS);
    localparam logic [SCORE_W-1:0]  c_score_max = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Tick prescaler (free running, independent of enable)
    // ------------------------------------------------------------------
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sensor synchroniser and debounce
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_sync1;
    logic [ADDR_W-1:0] r_sync2;
    logic [ADDR_W-1:0] r_prev;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_released;
    logic              w_change;
    logic              w_db_done;
    logic              w_strike;
    logic              w_release;

    assign w_change  = (r_sync2 != r_prev);
    // The tick that brings the stable count up to DEBOUNCE_TICKS; the
    // saturating counter guarantees this happens once per stable period.
    assign w_db_done = !w_change && w_tick && (r_db_cnt == c_db_last);
    assign w_strike  = w_db_done && (r_sync2 != '0) && r_released;
    assign w_release = w_db_done && (r_sync2 == '0);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_db_cnt   <= '0;
            // Start released so the first stable press after reset counts.
            r_released <= 1'b1;
        end else begin
            r_sync1 <= sensor_addr;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_change) begin
                r_db_cnt <= '0;
            end else if (w_tick && (r_db_cnt != c_db_full)) begin
                r_db_cnt <= r_db_cnt + c_db_w'(1);
            end
            if (w_strike) begin
                r_released <= 1'b0;
            end else if (w_release) begin
                r_released <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Judge FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [ADDR_W-1:0]  r_target;
    logic [c_win_w-1:0] r_win_cnt;
    logic               w_hit;
    logic               w_wrong;
    logic               w_miss;

    // A strike outranks window expiry; a reload in ARMED suppresses the miss.
    always_comb begin
        w_hit   = 1'b0;
        w_wrong = 1'b0;
        w_miss  = 1'b0;
        if ((r_state == ST_ARMED) && enable) begin
            if (w_strike) begin
                if (r_sync2 == r_target) begin
                    w_hit = 1'b1;
                end else begin
                    w_wrong = 1'b1;
                end
            end else if (!target_valid && (r_win_cnt == c_win_full)) begin
                w_miss = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_win_cnt <= '0;
        end else if (!enable) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (target_valid) begin
                        r_target  <= target_addr;
                        r_win_cnt <= '0;
                        r_state   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // The strike (if any) was judged against the old target
                    // in the combinational decode before this reload.
                    if (target_valid) begin
                        r_target  <= target_addr;
                        r_win_cnt <= '0;
                    end else if (w_hit) begin
                        r_state <= ST_COOLDOWN;
                    end else if (w_miss) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick && (r_win_cnt != c_win_full)) begin
                        r_win_cnt <= r_win_cnt + c_win_w'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Score, streak, pulses and sound timer
    // ------------------------------------------------------------------
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_streak;
    logic               r_hit_pulse;
    logic               r_wrong_pulse;
    logic               r_miss_pulse;
    logic [c_snd_w-1:0] r_snd_cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_score       <= '0;
            r_streak      <= '0;
            r_hit_pulse   <= 1'b0;
            r_wrong_pulse <= 1'b0;
            r_miss_pulse  <= 1'b0;
            r_snd_cnt     <= '0;
        end else begin
            r_hit_pulse   <= w_hit;
            r_wrong_pulse <= w_wrong;
            r_miss_pulse  <= w_miss;

            if (score_clear) begin
                r_score  <= '0;
                r_streak <= '0;
            end else if (w_hit) begin
                if (r_score != c_score_max) begin
                    r_score <= r_score + SCORE_W'(1);
                end
                if (r_streak != 8'hFF) begin
                    r_streak <= r_streak + 8'd1;
                end
            end else if (w_wrong) begin
                if (r_score != '0) begin
                    r_score <= r_score - SCORE_W'(1);
                end
                r_streak <= '0;
            end else if (w_miss) begin
                r_streak <= '0;
            end

            // A new hit retriggers the full sound duration.
            if (w_hit) begin
                r_snd_cnt <= c_snd_load;
            end else if (w_tick && (r_snd_cnt != '0)) begin
                r_snd_cnt <= r_snd_cnt - c_snd_w'(1);
            end
        end
    end

    assign score       = r_score;
    assign streak      = r_streak;
    assign hit_pulse   = r_hit_pulse;
    assign wrong_pulse = r_wrong_pulse;
    assign miss_pulse  = r_miss_pulse;
    assign play_sound  = (r_snd_cnt != '0);
    assign armed       = (r_state == ST_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_hit_judge_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_judge_core
// Purpose  : Randomised scoreboard bench for hit_judge_core. A timing-level
//            reference model derives strike, window and sound timing from tick
//            counts between events and queues expected pulses; a monitor pops
//            and compares them as the DUT presents pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_judge_core;

    localparam int T  = 4;
    localparam int D  = 2;
    localparam int W  = 10;
    localparam int S  = 3;
    localparam int SW = 3;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          enable;
    logic          score_clear;
    logic [2:0]    target_addr;
    logic          target_valid;
    logic [2:0]    sensor_addr;
    logic [SW-1:0] score;
    logic [7:0]    streak;
    logic          hit_pulse;
    logic          wrong_pulse;
    logic          miss_pulse;
    logic          play_sound;
    logic          armed;

    hit_judge_core #(
        .ADDR_W         (3),
        .TICK_DIV       (T),
        .DEBOUNCE_TICKS (D),
        .WINDOW_TICKS   (W),
        .SOUND_TICKS    (S),
        .SCORE_W        (SW)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .enable       (enable),
        .score_clear  (score_clear),
        .target_addr  (target_addr),
        .target_valid (target_valid),
        .sensor_addr  (sensor_addr),
        .score        (score),
        .streak       (streak),
        .hit_pulse    (hit_pulse),
        .wrong_pulse  (wrong_pulse),
        .miss_pulse   (miss_pulse),
        .play_sound   (play_sound),
        .armed        (armed)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: cycle index m_p counts rising edges since reset.
    // A tick occurs in cycle m when m % T == T-1.
    // ------------------------------------------------------------------
    typedef struct {
        int kind;     // 1 hit, 2 wrong, 4 miss
        int score;
        int streak;
    } exp_t;

    exp_t exp_q[$];
    int   sens_hist[$];
    int   m_p = 0, m_last_chg = -1, m_rel = 1, m_state = 0, m_tgt = 0, m_arm_p = 0;
    int   m_score = 0, m_streak = 0, m_have_hit = 0, m_hit_p = 0, m_armed = 0, m_play = 0;

    // Number of tick cycles in [a, b].
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / T - a / T;
    endfunction

    always @(posedge CLOCK_50 or posedge reset) begin
        int   v, vp;
        bit   tick, strike, rel_ev, hit, wrong, miss, tv;
        exp_t e;
        if (reset) begin
            m_p = 0; m_last_chg = -1; m_rel = 1; m_state = 0; m_tgt = 0; m_arm_p = 0;
            m_score = 0; m_streak = 0; m_have_hit = 0; m_hit_p = 0; m_armed = 0; m_play = 0;
            exp_q.delete();
            sens_hist.delete();
        end else begin
            sens_hist.push_back(int'(sensor_addr));
            // Two synchroniser stages: the value judged now was sampled two edges ago.
            v  = (m_p >= 2) ? sens_hist[m_p - 2] : 0;
            vp = (m_p >= 3) ? sens_hist[m_p - 3] : 0;
            tick   = ((m_p % T) == T - 1);
            tv     = target_valid;
            strike = 0; rel_ev = 0; hit = 0; wrong = 0; miss = 0;

            if (v != vp) begin
                m_last_chg = m_p;
            end else if (tick && ticks_in(m_last_chg + 1, m_p) == D) begin
                if (v != 0 && m_rel != 0) strike = 1;
                if (v == 0) rel_ev = 1;
            end
            if (strike) m_rel = 0;
            if (rel_ev) m_rel = 1;

            if (!enable) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: if (tv) begin
                        m_tgt = int'(target_addr); m_arm_p = m_p; m_state = 1;
                    end
                    1: begin
                        if (strike) begin
                            if (v == m_tgt) hit = 1; else wrong = 1;
                        end else if (!tv && ticks_in(m_arm_p + 1, m_p - 1) >= W) begin
                            miss = 1;
                        end
                        if (tv) begin
                            m_tgt = int'(target_addr); m_arm_p = m_p;
                        end else if (hit) begin
                            m_state = 2;
                        end else if (miss) begin
                            m_state = 0;
                        end
                    end
                    default: if (rel_ev) m_state = 0;
                endcase
            end

            if (score_clear) begin
                m_score = 0; m_streak = 0;
            end else if (hit) begin
                if (m_score < (1 << SW) - 1) m_score++;
                if (m_streak < 255) m_streak++;
            end else if (wrong) begin
                if (m_score > 0) m_score--;
                m_streak = 0;
            end else if (miss) begin
                m_streak = 0;
            end

            if (hit || wrong || miss) begin
                e.kind   = hit ? 1 : (wrong ? 2 : 4);
                e.score  = m_score;
                e.streak = m_streak;
                exp_q.push_back(e);
            end

            if (hit) begin
                m_have_hit = 1; m_hit_p = m_p;
            end
            m_play  = (m_have_hit != 0 && ticks_in(m_hit_p + 1, m_p) < S) ? 1 : 0;
            m_armed = (m_state == 1) ? 1 : 0;
            m_p++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever a pulse appears or one is due.
    // ------------------------------------------------------------------
    always @(negedge CLOCK_50) begin
        exp_t        e;
        logic [31:0] k;
        if (reset === 1'b0) begin
            k = {29'd0, miss_pulse, wrong_pulse, hit_pulse};
            if (exp_q.size() == 0) begin
                if (k != 0) check("unexpected_pulse", k, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", k, e.kind);
                check("pulse_score", 32'(score), e.score);
                check("pulse_streak", 32'(streak), e.streak);
            end
            check("armed", 32'(armed), m_armed);
            check("play_sound", 32'(play_sound), m_play);
            check("score", 32'(score), m_score);
            check("streak", 32'(streak), m_streak);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int hold_left = 0;

    task automatic step_random();
        int r;
        @(negedge CLOCK_50);
        if (hold_left == 0) begin
            r = $urandom_range(0, 9);
            if (r < 5)      sensor_addr = 3'(m_tgt);
            else if (r < 7) sensor_addr = 3'($urandom_range(1, 7));
            else            sensor_addr = 3'd0;
            // Short holds model contact bounce and must never strike.
            hold_left = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(4, 30);
        end
        hold_left--;
        target_valid = ($urandom_range(0, 29) == 0);
        target_addr  = 3'($urandom_range(0, 7));
        enable       = ($urandom_range(0, 149) != 0);
        score_clear  = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int guard;
        reset        = 1'b1;
        enable       = 1'b0;
        score_clear  = 1'b0;
        target_addr  = '0;
        target_valid = 1'b0;
        sensor_addr  = '0;
        repeat (3) @(negedge CLOCK_50);
        #1;
        check("reset_score", 32'(score), 0);
        check("reset_armed", 32'(armed), 0);
        #1 reset = 1'b0;

        repeat (3000) step_random();

        // Reach an armed state with a nonzero score, then reset mid-window.
        guard = 0;
        while (!(m_state == 1 && m_score > 0) && guard < 5000) begin
            step_random();
            guard++;
        end
        @(negedge CLOCK_50);
        target_valid = 1'b0;
        score_clear  = 1'b0;
        enable       = 1'b1;
        sensor_addr  = 3'd3;
        #2 reset = 1'b1;
        #1;
        check("async_reset_score", 32'(score), 0);
        check("async_reset_streak", 32'(streak), 0);
        check("async_reset_hit", 32'(hit_pulse), 0);
        check("async_reset_wrong", 32'(wrong_pulse), 0);
        check("async_reset_miss", 32'(miss_pulse), 0);
        check("async_reset_sound", 32'(play_sound), 0);
        check("async_reset_armed", 32'(armed), 0);
        repeat (3) @(negedge CLOCK_50);
        #2 reset = 1'b0;

        // Held sensor with no target: strikes land in IDLE and are ignored.
        repeat (40) @(negedge CLOCK_50);

        hold_left = 0;
        repeat (15000) step_random();

        @(negedge CLOCK_50);
        target_valid = 1'b0;
        score_clear  = 1'b0;
        enable       = 1'b1;
        sensor_addr  = 3'd0;
        repeat (80) @(negedge CLOCK_50);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
